// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures PWM period/high time and recovers a 10-bit duty code.
// Define PWM_DEC_DIR_EN to add the {IN1,IN2} direction decode (in_pins/motor_state).
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [9:0] duty,
  output logic       duty_valid,
  output logic       signal_lost,
  output logic       overrun
`ifdef PWM_DEC_DIR_EN
  ,
  input  logic [1:0] in_pins,
  output logic [1:0] motor_state
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT);
  localparam logic [9:0]       LP_MAX = 10'd1023;

  state_t           r_state;
  state_t           w_state_nx;
  logic             r_sync1;
  logic             r_s;
  logic             r_s_d;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_cap;
  logic             r_armed;
  logic             r_to_done;
  logic             r_sat;
  logic [CNT_W:0]   r_rem;
  logic [CNT_W:0]   r_p;
  logic [8:0]       r_q;
  logic [3:0]       r_step;

  logic             w_rise;
  logic             w_fall;
  logic             w_timeout;
  logic             w_accept;
  logic             w_drop;
  logic             w_last;
  logic             w_ge;
  logic [CNT_W:0]   w_rem_sh;
  logic [CNT_W:0]   w_rem_nx;
  logic [9:0]       w_q_nx;

  assign w_rise    = r_s & ~r_s_d;
  assign w_fall    = ~r_s & r_s_d;
  // r_to_done blocks a repeat timeout while cnt sits saturated
  assign w_timeout = (r_cnt == LP_TO) & ~r_to_done & ~w_rise;
  assign w_accept  = w_rise & r_armed & (r_state != DIV);
  assign w_drop    = w_rise & r_armed & (r_state == DIV);
  assign w_last    = (r_state == DIV) & (r_step == 4'd9);

  assign w_rem_sh  = r_rem << 1;
  assign w_ge      = (w_rem_sh >= r_p);
  assign w_rem_nx  = w_ge ? (w_rem_sh - r_p) : w_rem_sh;
  assign w_q_nx    = {r_q, w_ge};

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nx = DIV;
      DIV:     if (w_last) w_state_nx = DONE;
      DONE:    w_state_nx = w_accept ? DIV : IDLE;
      default: w_state_nx = IDLE;
    endcase
    if (w_timeout) w_state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sync1     <= 1'b0;
      r_s         <= 1'b0;
      r_s_d       <= 1'b0;
      r_cnt       <= '0;
      r_hi_cap    <= '0;
      r_armed     <= 1'b0;
      r_to_done   <= 1'b0;
      r_sat       <= 1'b0;
      r_rem       <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_step      <= '0;
      duty        <= '0;
      duty_valid  <= 1'b0;
      signal_lost <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sync1 <= pwm_in;
      r_s     <= r_sync1;
      r_s_d   <= r_s;

      if (w_rise) r_cnt <= CNT_W'(1);
      else if (r_cnt != LP_TO) r_cnt <= r_cnt + 1'b1;

      if (w_fall) r_hi_cap <= r_cnt;

      if (w_rise) r_to_done <= 1'b0;
      else if (w_timeout) r_to_done <= 1'b1;

      if (w_rise & ~r_armed) r_armed <= 1'b1;

      duty_valid <= 1'b0;
      overrun    <= w_drop;

      if (w_accept) begin
        r_p    <= {1'b0, r_cnt};
        r_rem  <= {1'b0, r_hi_cap};
        r_q    <= '0;
        r_step <= '0;
        r_sat  <= (r_hi_cap >= r_cnt);
      end else if (r_state == DIV) begin
        r_rem  <= w_rem_nx;
        r_q    <= w_q_nx[8:0];
        r_step <= r_step + 4'd1;
      end

      if (w_timeout) begin
        duty        <= r_s ? LP_MAX : 10'd0;
        duty_valid  <= 1'b1;
        signal_lost <= 1'b1;
        r_armed     <= 1'b0;
      end else if (w_last) begin
        duty        <= r_sat ? LP_MAX : w_q_nx;
        duty_valid  <= 1'b1;
        signal_lost <= 1'b0;
      end
    end
  end

`ifdef PWM_DEC_DIR_EN
  logic [1:0] r_pin1;
  logic [1:0] r_pin2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pin1      <= 2'b00;
      r_pin2      <= 2'b00;
      motor_state <= 2'b00;
    end else begin
      r_pin1 <= in_pins;
      r_pin2 <= r_pin1;
      unique case (1'b1)
        (r_pin2 == 2'b10): motor_state <= 2'b01;
        (r_pin2 == 2'b01): motor_state <= 2'b10;
        default:           motor_state <= 2'b00;
      endcase
    end
  end
`endif

endmodule
